// File: rtl/branch_flush_controller_pkg.sv
// Shared types and constants for the execute-stage branch/flush controller.
// Enumerations here are used by the controller, its condition evaluator and the interface.
package branch_pkg;

  typedef enum logic [1:0] {
    COND_EQ   = 2'b00,
    COND_RSVD = 2'b01,
    COND_GT   = 2'b10,
    COND_AL   = 2'b11
  } cond_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bc_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_flush_controller_if.sv
// Execute-stage <-> branch controller signal bundle.
// The master drives the execute-stage inputs; the slave (controller) drives the flags, redirect and flush.
interface branch_flush_controller_if #(parameter int ADDR_W = 32);
  import branch_pkg::*;

  logic              ValidE;
  logic              BranchE;
  logic [1:0]        InstrSelE;
  logic              FlagWriteE;
  logic [3:0]        ALUFlagsE;
  logic [ADDR_W-1:0] BranchTargetE;
  logic              Stall;
  logic [3:0]        Flags;
  logic              CondExE;
  logic              PCSrc;
  logic [ADDR_W-1:0] PCTarget;
  logic              FlushD;
  logic              FlushE;
  logic              Busy;
  bc_state_t         state_dbg;

  modport master (
    output ValidE, BranchE, InstrSelE, FlagWriteE, ALUFlagsE, BranchTargetE, Stall,
    input  Flags, CondExE, PCSrc, PCTarget, FlushD, FlushE, Busy, state_dbg
  );

  modport slave (
    input  ValidE, BranchE, InstrSelE, FlagWriteE, ALUFlagsE, BranchTargetE, Stall,
    output Flags, CondExE, PCSrc, PCTarget, FlushD, FlushE, Busy, state_dbg
  );

endinterface

// File: rtl/branch_flush_controller_cond_eval.sv
// Combinational condition evaluator: decides whether the Execute instruction's
// condition passes against the committed NZCV flags. Non-branches always pass.
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic       Branch,
  input  logic [1:0] InstrSel,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic unused_carry;
  assign unused_carry = Flags[FLAG_C];

  always_comb begin
    CondEx = 1'b1;
    if (Branch) begin
      case (cond_sel_t'(InstrSel))
        COND_EQ:   CondEx = Flags[FLAG_Z];
        COND_GT:   CondEx = ~Flags[FLAG_Z] & ~(Flags[FLAG_N] ^ Flags[FLAG_V]);
        COND_AL:   CondEx = 1'b1;
        default:   CondEx = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_flush_controller.sv
// Execute-stage branch controller: owns NZCV, resolves branches, redirects PC and sequences the D/E flush.
// Optional BRANCH_PERF_EN adds saturating BranchCount/TakenCount outputs.
module branch_flush_controller
  import branch_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2   // legal 1..15
) (
  input  logic clk,
  input  logic rst,
  branch_flush_controller_if.slave bus
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0] BranchCount,
  output logic [31:0] TakenCount
`endif
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  bc_state_t  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex;
  logic       effective;
  logic       taken;

  branch_cond_eval u_cond (
    .Branch   (bus.BranchE),
    .InstrSel (bus.InstrSelE),
    .Flags    (flags_q),
    .CondEx   (cond_ex)
  );

  // rst gates the combinational redirect so every output reads 0 while reset is held.
  assign effective = bus.ValidE & ~bus.Stall & (state_q == RUN) & ~rst;
  assign taken     = effective & bus.BranchE & cond_ex;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    if (effective && bus.FlagWriteE && cond_ex) flags_d = bus.ALUFlagsE;
    case (state_q)
      RUN: begin
        if (taken && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (!bus.Stall) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      flags_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign bus.Flags     = flags_q;
  assign bus.CondExE   = cond_ex;
  assign bus.PCSrc     = taken;
  assign bus.PCTarget  = rst ? {ADDR_W{1'b0}} : bus.BranchTargetE;
  assign bus.FlushD    = taken | (state_q == FLUSH);
  assign bus.FlushE    = taken | (state_q == FLUSH);
  assign bus.Busy      = (state_q == FLUSH);
  assign bus.state_dbg = state_q;

`ifdef BRANCH_PERF_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (effective && bus.BranchE && (branch_cnt_q != 32'hFFFF_FFFF))
      branch_cnt_d = branch_cnt_q + 32'd1;
    if (taken && (taken_cnt_q != 32'hFFFF_FFFF))
      taken_cnt_d = taken_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q <= 32'd0;
      taken_cnt_q  <= 32'd0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign BranchCount = branch_cnt_q;
  assign TakenCount  = taken_cnt_q;
`endif

endmodule

// File: doc/branch_flush_controller.md
Name: branch_flush_controller

Overview:
Execute-stage branch controller for the SIMD AES core's scalar control path. Owns the architectural NZCV flag register and resolves conditional branches (EQ, GT, unconditional) against the committed flags. On a taken branch it redirects the PC and sequences a multi-cycle flush of the Decode and Execute stages. It sits between the execute-stage decode/ALU outputs and the fetch/hazard logic.

Parameters:
ADDR_W, 32, width of the PC/branch target.
FLUSH_CYCLES, 2, cycles FlushD/FlushE stay high per taken branch; legal range 1..15.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ValidE  in  1  instruction in Execute is valid (not a bubble)
BranchE  in  1  Execute instruction is a branch
InstrSelE  in  2  condition select: 00 EQ, 01 reserved, 10 GT (signed), 11 unconditional
FlagWriteE  in  1  Execute instruction updates flags
ALUFlagsE  in  4  ALU result flags {N,Z,C,V}
BranchTargetE  in  ADDR_W  computed branch target
Stall  in  1  pipeline hold from hazard unit
Flags  out  4  committed flag register {N,Z,C,V}
CondExE  out  1  condition passed for the Execute instruction
PCSrc  out  1  redirect fetch to PCTarget this cycle
PCTarget  out  ADDR_W  redirect address
FlushD  out  1  flush Decode register
FlushE  out  1  flush Execute register
Busy  out  1  flush sequence in progress

Behaviour:
- Reset (async, any state): Flags=0, FSM=RUN, flush counter=0. PCSrc, FlushD, FlushE, Busy=0. PCTarget=0.
- Condition evaluation is combinational on the registered Flags:
  - EQ: Z.
  - GT: ~Z & ~(N^V).
  - 11: 1.
  - 01: 0.
  - Non-branch: CondExE=1.
- Effective instruction: ValidE & ~Stall & (state==RUN).
- Flag write: on effective & FlagWriteE & CondExE, Flags <= ALUFlagsE at the next edge. A flag-writing branch evaluates on the old flags and writes the new ones in the same cycle.
- Taken branch: effective & BranchE & CondExE.
  - Same cycle, combinational: PCSrc=1, PCTarget=BranchTargetE, FlushD=FlushE=1.
  - Next edge: if FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
- A not-taken or reserved branch produces no redirect and no flush.
- FSM states:
  - RUN: resolve as above. Busy=0.
  - FLUSH: FlushD=FlushE=1, Busy=1, PCSrc=0. ValidE is ignored, so no flag writes and no resolution occur.
    - Counter decrements each cycle with Stall=0 and is frozen while Stall=1.
    - Transition to RUN on the edge where the counter goes 1->0.
- Stall in RUN: no flag write, no redirect, no flush. The branch is re-evaluated once Stall drops.
- Outside a redirect, PCTarget holds BranchTargetE (don't-care for the consumer).
- Reset asserted mid-FLUSH aborts the sequence immediately; after release the FSM is in RUN.

Optional Feature:
BRANCH_PERF_EN:
- Defined: adds outputs BranchCount[31:0] and TakenCount[31:0].
  - BranchCount increments on every effective branch; TakenCount on every taken branch.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package branch_pkg:
  - cond_sel_t enum (COND_EQ=2'b00, COND_RSVD=2'b01, COND_GT=2'b10, COND_AL=2'b11).
  - bc_state_t enum (RUN, FLUSH).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One combinational sub-module, branch_cond_eval (Branch, InstrSel, Flags -> CondEx). The FSM, flag register and counters stay in the top.

Test Plan:
1. Reset then ALU op with FlagWriteE=1, ALUFlagsE=4'b0100 -> Flags=4'b0100 next cycle. Then EQ branch to 0x40 -> PCSrc=1, PCTarget=0x40, FlushD/FlushE high for exactly 2 cycles, Busy high for 1.
2. Flags=4'b1000 (N=1, V=0), GT branch -> CondExE=0, PCSrc=0, no flush. Flags=4'b1001 -> GT taken.
3. InstrSelE=01 branch with any flags -> never taken. InstrSelE=11 with Flags=0 -> taken.
4. Stall=1 during a taken branch -> no PCSrc. Stall=1 for 3 cycles inside FLUSH -> counter frozen, total flush length is 2+3 cycles.
5. Valid flag-writing instruction presented during FLUSH -> Flags unchanged. Reset asserted in the first FLUSH cycle -> all outputs 0 asynchronously, RUN after release.
6. With BRANCH_PERF_EN: 5 branches, 3 taken -> BranchCount=5, TakenCount=3. Preload near max -> counters saturate at 32'hFFFF_FFFF.
